// File: rtl/next_pc_unit.sv
// Next-PC generator with LUT jumps, a circular return-address stack and the
// start/done run-control FSM that gates PC updates.
module next_pc_unit #(
  parameter int unsigned PC_W      = 12,
  parameter int unsigned LUT_DEPTH = 16,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned LUT_IW   = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1,
  localparam int unsigned RAS_IW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1,
  localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_start,
  input  logic              halt,
  input  logic [PC_W-1:0]   pc_cur,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              call,
  input  logic              ret,
  input  logic [LUT_IW-1:0] lut_idx,
  input  logic [7:0]        rel_off,
  input  logic              lut_we,
  input  logic [LUT_IW-1:0] lut_waddr,
  input  logic [PC_W-1:0]   lut_wdata,
  output logic [PC_W-1:0]   pc_next,
  output logic              start,
  output logic              done,
  output logic              ras_ovf,
  output logic              ras_unf
);

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic              done_q, done_d;

  logic [PC_W-1:0]   lut_q [LUT_DEPTH];
  logic [PC_W-1:0]   ras_q [RAS_DEPTH];
  // sp_q points at the next write slot; the top entry sits just below it.
  logic [RAS_IW-1:0] sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic [RAS_IW-1:0] sp_inc, sp_dec;
  logic [PC_W-1:0]   pc_inc, rel_sext, ras_top, lut_rd;
  logic              ras_empty, ras_full, active, go;
  logic              push, pop, ovf_evt, unf_evt;

  // Stack pointer arithmetic, decoded control and flag events.
  always_comb begin
    sp_inc    = (sp_q == RAS_IW'(RAS_DEPTH - 1)) ? '0 : sp_q + RAS_IW'(1);
    sp_dec    = (sp_q == '0) ? RAS_IW'(RAS_DEPTH - 1) : sp_q - RAS_IW'(1);
    pc_inc    = pc_cur + PC_W'(1);
    rel_sext  = {{(PC_W - 8){rel_off[7]}}, rel_off};
    ras_top   = ras_q[sp_dec];
    lut_rd    = lut_q[lut_idx];
    ras_empty = (cnt_q == '0);
    ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
    active    = (state_q == StRun) && !halt;
    go        = (state_q == StIdle) && req_start;
    pop       = active && ret && !ras_empty;
    push      = active && !ret && call;
    unf_evt   = active && ret && ras_empty;
    ovf_evt   = push && ras_full;
  end

  // Next-PC selection; ret outranks call, which outranks jump and branch.
  always_comb begin
    pc_next = pc_cur;
    if (active) begin
      if (ret) begin
        pc_next = ras_empty ? pc_inc : ras_top;
      end else if (call || jump) begin
        pc_next = lut_rd;
      end else if (branch_taken) begin
        pc_next = pc_cur + rel_sext;
      end else begin
        pc_next = pc_inc;
      end
    end
  end

  // FSM next state; start/done are registered decodes of the next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (req_start) state_d = StRun;
      StRun:    if (halt)      state_d = StHalted;
      StHalted: if (req_start) state_d = StIdle;
      default:                 state_d = StIdle;
    endcase
    start_d = (state_d == StIdle);
    done_d  = (state_d == StHalted);
  end

  // Stack occupancy and sticky flags; a new run clears both.
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q | ovf_evt;
    unf_d = unf_q | unf_evt;
    if (go) begin
      sp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (pop) begin
      sp_d  = sp_dec;
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push) begin
      sp_d  = sp_inc;
      cnt_d = ras_full ? cnt_q : cnt_q + CNT_W'(1);
    end
  end

  // Run-control FSM with registered Moore outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      start_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      done_q  <= done_d;
    end
  end

  // Stack bookkeeping, flags and the jump-target LUT.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < LUT_DEPTH; i++) lut_q[i] <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (lut_we) lut_q[lut_waddr] <= lut_wdata;
    end
  end

  // Stack storage; a full push lands on the oldest slot.
  always_ff @(posedge clk) begin
    if (reset && push) ras_q[sp_q] <= pc_inc;
  end

  assign start   = start_q;
  assign done    = done_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule
